// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL power-up / lock sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pll_seq_pkg;

    localparam int PLL_SEQ_CNT_W  = 16;
    localparam int PLL_SEQ_TICK_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CP_ON,
        VCO_ON,
        MEASURE,
        RETRY_OFF,
        LOCKED,
        FAIL
    } pll_seq_state_t;

    // Registered output image, one bit per macro/control pin.
    typedef struct packed {
        logic en_cp;
        logic en_vco;
        logic clk_sel;
        logic locked;
        logic fail;
    } pll_seq_outs_t;

    // Output values that belong to each state; the FSM loads these on the
    // same edge that enters the state, so outputs never lag the state.
    function automatic pll_seq_outs_t pll_seq_outs(input pll_seq_state_t s);
        pll_seq_outs_t o;
        o = '0;
        case (s)
            CP_ON: begin
                o.en_cp = 1'b1;
            end
            VCO_ON, MEASURE: begin
                o.en_cp  = 1'b1;
                o.en_vco = 1'b1;
            end
            LOCKED: begin
                o.en_cp   = 1'b1;
                o.en_vco  = 1'b1;
                o.clk_sel = 1'b1;
                o.locked  = 1'b1;
            end
            FAIL: begin
                o.fail = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    // True when |cnt - exp_ticks| <= tol, evaluated in signed integer range
    // so a tolerance wider than the expected count cannot wrap.
    function automatic logic pll_seq_in_tol(input logic [PLL_SEQ_TICK_W-1:0] cnt,
                                            input int exp_ticks,
                                            input int tol);
        int diff;
        diff = int'(cnt) - exp_ticks;
        if (diff < 0) begin
            diff = -diff;
        end
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// Control and status bundle between the system controller and the PLL sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request, pll_tick a free-running pulse.
interface pll_lock_seq_if;

    logic start;
    logic pll_tick;
    logic ENb_CP;
    logic ENb_VCO;
    logic clk_sel;
    logic locked;
    logic fail;

    // Controller side: requests the PLL and supplies the divided PLL tick.
    modport master (
        output start,
        output pll_tick,
        input  ENb_CP,
        input  ENb_VCO,
        input  clk_sel,
        input  locked,
        input  fail
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  pll_tick,
        output ENb_CP,
        output ENb_VCO,
        output clk_sel,
        output locked,
        output fail
    );

endinterface

// File: rtl/pll_tick_counter.sv
// Counts pll_tick pulses over a WINDOW-cycle window and compares against EXP_TICKS +/- TOL.
// Latency: done/pass are valid combinationally on the last window cycle (tick on that cycle included).
// Backpressure: none; dropping run clears the window so the FSM can restart it at will.
module pll_tick_counter
    import pll_seq_pkg::*;
#(
    parameter int WINDOW    = 64,
    parameter int EXP_TICKS = 8,
    parameter int TOL       = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic run,
    input  logic tick,
    output logic done,
    output logic pass
);

    localparam logic [PLL_SEQ_CNT_W-1:0] WIN_LAST = PLL_SEQ_CNT_W'(WINDOW - 1);

    logic [PLL_SEQ_CNT_W-1:0]  win_cnt;
    logic [PLL_SEQ_TICK_W-1:0] tick_cnt;
    logic [PLL_SEQ_TICK_W-1:0] tick_sum;

    // Saturating count including the tick present this cycle, so the final
    // window cycle contributes to the verdict issued on that same edge.
    assign tick_sum = (tick && (tick_cnt != '1)) ? (tick_cnt + PLL_SEQ_TICK_W'(1)) : tick_cnt;

    assign done = run && (win_cnt == WIN_LAST);
    assign pass = pll_seq_in_tol(tick_sum, EXP_TICKS, TOL);

    // Window/tick accumulation; a finished window rolls straight into the next.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            win_cnt  <= '0;
            tick_cnt <= '0;
        end else if (!run || done) begin
            win_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + PLL_SEQ_CNT_W'(1);
            tick_cnt <= tick_sum;
        end
    end

endmodule

// File: rtl/pll_lock_seq.sv
// Power-up/lock sequencer for the avsdpll: CP enable, VCO enable, settle, frequency check, clock handover.
// Latency: outputs registered; nominal lock CP_SETTLE+LOCK_WAIT+WINDOW edges after start (PLL_SEQ_MONITOR_EN adds continuous re-measure in LOCKED).
// Backpressure: none; start=0 or RST_N=0 returns everything to idle on the next edge.
module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int CP_SETTLE = 16,
    parameter int LOCK_WAIT = 256,
    parameter int WINDOW    = 64,
    parameter int EXP_TICKS = 8,
    parameter int TOL       = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    pll_lock_seq_if.slave seq_if
);

    localparam logic [PLL_SEQ_CNT_W-1:0] CP_LAST   = PLL_SEQ_CNT_W'(CP_SETTLE - 1);
    localparam logic [PLL_SEQ_CNT_W-1:0] LOCK_LAST = PLL_SEQ_CNT_W'(LOCK_WAIT - 1);
    localparam logic [PLL_SEQ_CNT_W-1:0] RETRY_MAX = PLL_SEQ_CNT_W'(MAX_RETRY);

    pll_seq_state_t           state;
    pll_seq_outs_t            outs;
    logic [PLL_SEQ_CNT_W-1:0] dur_cnt;
    logic [PLL_SEQ_CNT_W-1:0] retry_cnt;
    logic                     win_run;
    logic                     win_done;
    logic                     win_pass;

    // The measurement window runs only while the loop is being checked;
    // with the monitor enabled LOCKED keeps checking back-to-back windows.
`ifdef PLL_SEQ_MONITOR_EN
    assign win_run = (state == MEASURE) || (state == LOCKED);
`else
    assign win_run = (state == MEASURE);
`endif

    pll_tick_counter #(
        .WINDOW    (WINDOW),
        .EXP_TICKS (EXP_TICKS),
        .TOL       (TOL)
    ) u_tick_counter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .run   (win_run),
        .tick  (seq_if.pll_tick),
        .done  (win_done),
        .pass  (win_pass)
    );

    assign seq_if.ENb_CP  = outs.en_cp;
    assign seq_if.ENb_VCO = outs.en_vco;
    assign seq_if.clk_sel = outs.clk_sel;
    assign seq_if.locked  = outs.locked;
    assign seq_if.fail    = outs.fail;

    // Sequencer FSM with duration/retry counters; outputs are loaded together
    // with the next state so clk_sel can never lead ENb_VCO.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            outs      <= '0;
            dur_cnt   <= '0;
            retry_cnt <= '0;
        end else if (!seq_if.start) begin
            state     <= IDLE;
            outs      <= '0;
            dur_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= CP_ON;
                    outs      <= pll_seq_outs(CP_ON);
                    dur_cnt   <= '0;
                    retry_cnt <= '0;
                end
                CP_ON: begin
                    if (dur_cnt == CP_LAST) begin
                        state   <= VCO_ON;
                        outs    <= pll_seq_outs(VCO_ON);
                        dur_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + PLL_SEQ_CNT_W'(1);
                    end
                end
                VCO_ON: begin
                    if (dur_cnt == LOCK_LAST) begin
                        state   <= MEASURE;
                        outs    <= pll_seq_outs(MEASURE);
                        dur_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + PLL_SEQ_CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (win_done) begin
                        if (win_pass) begin
                            state <= LOCKED;
                            outs  <= pll_seq_outs(LOCKED);
                        end else if (retry_cnt < RETRY_MAX) begin
                            state     <= RETRY_OFF;
                            outs      <= pll_seq_outs(RETRY_OFF);
                            retry_cnt <= retry_cnt + PLL_SEQ_CNT_W'(1);
                            dur_cnt   <= '0;
                        end else begin
                            state <= FAIL;
                            outs  <= pll_seq_outs(FAIL);
                        end
                    end
                end
                RETRY_OFF: begin
                    if (dur_cnt == CP_LAST) begin
                        state   <= CP_ON;
                        outs    <= pll_seq_outs(CP_ON);
                        dur_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + PLL_SEQ_CNT_W'(1);
                    end
                end
                LOCKED: begin
`ifdef PLL_SEQ_MONITOR_EN
                    // Losing frequency in service starts a fresh retry budget.
                    if (win_done && !win_pass) begin
                        state     <= RETRY_OFF;
                        outs      <= pll_seq_outs(RETRY_OFF);
                        retry_cnt <= '0;
                        dur_cnt   <= '0;
                    end
`else
                    state <= LOCKED;
`endif
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= IDLE;
                    outs  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Randomized bench for pll_lock_seq against an attempt-level schedule model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pll_lock_seq;

    localparam int CP       = 16;
    localparam int LW       = 256;
    localparam int WIN      = 64;
    localparam int EXP      = 8;
    localparam int TOL      = 1;
    localparam int MAXR     = 3;
    localparam int MEAS_END = CP + LW + WIN;      // window-end edge of an attempt
    localparam int ATT      = 2 * CP + LW + WIN;  // edges per failed attempt
    localparam int PLAN_N   = 1600;

    // {ENb_CP, ENb_VCO, clk_sel, locked, fail}
    localparam logic [4:0] O_OFF  = 5'b00000;
    localparam logic [4:0] O_CP   = 5'b10000;
    localparam logic [4:0] O_RUN  = 5'b11000;
    localparam logic [4:0] O_LOCK = 5'b11110;
    localparam logic [4:0] O_FAIL = 5'b00001;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   plan [PLAN_N];

    pll_lock_seq_if bus ();

    pll_lock_seq dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .seq_if (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0b exp %0b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs_now();
        return {bus.ENb_CP, bus.ENb_VCO, bus.clk_sel, bus.locked, bus.fail};
    endfunction

    function automatic int ticks_in(input int a, input int z);
        int n;
        n = 0;
        for (int i = a; i <= z; i++) begin
            n += int'(plan[i]);
        end
        return n;
    endfunction

    function automatic bit win_ok(input int n);
        return (n >= EXP - TOL) && (n <= EXP + TOL);
    endfunction

    // Expected outputs after relative edge e (edge 0 = start seen in idle),
    // derived attempt by attempt from the timing rules and the planned ticks.
    function automatic logic [4:0] model(input int e);
        logic [4:0] res;
        bit         fin;
        int         b;
        int         r;
        int         w;
        bit         fell;
        res  = O_OFF;
        fin  = 1'b0;
        b    = 0;
        r    = 0;
        w    = 0;
        fell = 1'b0;
        while (!fin) begin
            if (e < b + CP) begin
                res = O_CP;
                fin = 1'b1;
            end else if (e < b + MEAS_END) begin
                res = O_RUN;
                fin = 1'b1;
            end else if (win_ok(ticks_in(b + MEAS_END - WIN + 1, b + MEAS_END))) begin
`ifdef PLL_SEQ_MONITOR_EN
                w    = b + MEAS_END;
                fell = 1'b0;
                while (!fin && !fell) begin
                    w += WIN;
                    if (e < w) begin
                        res = O_LOCK;
                        fin = 1'b1;
                    end else if (!win_ok(ticks_in(w - WIN + 1, w))) begin
                        fell = 1'b1;
                        r    = 0;
                        b    = w + CP;
                        if (e < b) begin
                            res = O_OFF;
                            fin = 1'b1;
                        end
                    end
                end
`else
                res = O_LOCK;
                fin = 1'b1;
`endif
            end else if (r < MAXR) begin
                r++;
                if (e < b + ATT) begin
                    res = O_OFF;
                    fin = 1'b1;
                end else begin
                    b += ATT;
                end
            end else begin
                res = O_FAIL;
                fin = 1'b1;
            end
        end
        return res;
    endfunction

    // start low with random ticks: everything must stay off.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start    = 1'b0;
            bus.pll_tick = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1;
            check($sformatf("idle@%0d", i), outs_now(), O_OFF);
        end
    endtask

    // mode 0: period arg; 1: random 1-in-arg; 2: exactly arg ticks in the
    // first window only; 3: period 8 degrading to period 16 over [401,600).
    task automatic run_scn(input string name, input int mode, input int arg,
                           input int len, input bit end_rst);
        int ph;
        int placed;
        int pos;
        ph = $urandom_range(0, 15);
        for (int i = 0; i < PLAN_N; i++) begin
            plan[i] = 1'b0;
        end
        case (mode)
            0: for (int i = 0; i < PLAN_N; i++) plan[i] = ((i + ph) % arg) == 0;
            1: for (int i = 0; i < PLAN_N; i++) plan[i] = ($urandom_range(0, arg - 1) == 0);
            2: begin
                placed = 0;
                while (placed < arg) begin
                    pos = $urandom_range(MEAS_END - WIN + 1, MEAS_END);
                    if (!plan[pos]) begin
                        plan[pos] = 1'b1;
                        placed++;
                    end
                end
            end
            default: for (int i = 0; i < PLAN_N; i++) begin
                if (i > 400 && i < 600) plan[i] = ((i + ph) % 16) == 0;
                else                    plan[i] = ((i + ph) % 8) == 0;
            end
        endcase
        for (int e = 0; e < len; e++) begin
            RST_N        = 1'b1;
            bus.start    = 1'b1;
            bus.pll_tick = plan[e];
            @(posedge CLK);
            #1;
            check($sformatf("%s@%0d", name, e), outs_now(), model(e));
        end
        bus.pll_tick = 1'($urandom_range(0, 1));
        if (end_rst) RST_N = 1'b0;
        else         bus.start = 1'b0;
        @(posedge CLK);
        #1;
        check($sformatf("%s_end", name), outs_now(), O_OFF);
        RST_N        = 1'b1;
        bus.pll_tick = 1'b0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.pll_tick = 1'b0;
        RST_N        = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset", outs_now(), O_OFF);
        RST_N = 1'b1;
        idle_gap(5);

        run_scn("nominal", 0, 8, 400, 1'b0);
        idle_gap(3);
        run_scn("tick7", 2, 7, 400, 1'b0);
        run_scn("tick9", 2, 9, 400, 1'b0);
        run_scn("tick6", 2, 6, 700, 1'b0);
        run_scn("noticks", 2, 0, 1420, 1'b0);
        run_scn("drop100", 0, 8, 100, 1'b0);
        run_scn("restart", 0, 8, 400, 1'b1);
        run_scn("relock", 0, 8, 340, 1'b0);
        run_scn("drop_at_win", 2, 8, MEAS_END, 1'b0);
        idle_gap(2);
        run_scn("degrade", 3, 0, 900, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_scn($sformatf("rand%0d", k), 1, $urandom_range(6, 9),
                    $urandom_range(300, 1450), 1'($urandom_range(0, 1)));
            idle_gap(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Synchronous power-up and lock sequencer for the avsdpll clock multiplier. It enables the charge pump, then the VCO, and waits for the loop to settle. It then checks the PLL output frequency against the reference clock by counting a divided PLL tick over a fixed window, and only then hands the PLL clock to the core through `clk_sel`. On a frequency miss it retries a bounded number of times and flags failure.

## Interface
Parameters:
- `CP_SETTLE`, 16: cycles between charge-pump enable and VCO enable; also the off time before a retry.
- `LOCK_WAIT`, 256: cycles allowed for loop settling after VCO enable.
- `WINDOW`, 64: measurement window in cycles.
- `EXP_TICKS`, 8: expected `pll_tick` count per window (8x multiplier, divide-by-64 tick).
- `TOL`, 1: allowed absolute deviation from `EXP_TICKS`.
- `MAX_RETRY`, 3: failed measurements tolerated before FAIL.

Ports:
- `CLK` input 1: reference-domain clock. One clock only; reset is synchronous and active-low.
- `RST_N` input 1: synchronous active-low reset.
- `start` input 1: level; 1 requests the PLL, 0 shuts it down.
- `pll_tick` input 1: single-cycle pulse, already synchronized to `CLK`, one per 64 PLL output cycles.
- `ENb_CP` output 1: charge-pump enable to the PLL macro. 1 = run (macro pin polarity).
- `ENb_VCO` output 1: VCO enable to the PLL macro. 1 = oscillate, 0 = output held low.
- `clk_sel` output 1: 1 selects the PLL clock at the downstream glitch-free mux.
- `locked` output 1: frequency check passed.
- `fail` output 1: retries exhausted.

## Operation
- All outputs are registered.
- Reset values: `ENb_CP`=0, `ENb_VCO`=0, `clk_sel`=0, `locked`=0, `fail`=0. State is IDLE and all counters are 0.
- IDLE: all outputs 0. If `start`=1, go to CP_ON and clear the retry count.
- CP_ON: `ENb_CP`=1. After `CP_SETTLE` cycles, go to VCO_ON.
- VCO_ON: `ENb_CP`=1, `ENb_VCO`=1. After `LOCK_WAIT` cycles, go to MEASURE.
- MEASURE: enables stay 1. Count `pll_tick` over exactly `WINDOW` cycles; the tick on the last window cycle is counted. The tick counter is 8 bits and saturates at 255. At window end:
  - |count − `EXP_TICKS`| ≤ `TOL`: go to LOCKED.
  - Otherwise, if retries < `MAX_RETRY`: increment retries and go to RETRY_OFF.
  - Otherwise: go to FAIL.
- RETRY_OFF: both enables 0 for `CP_SETTLE` cycles, then go to CP_ON. The retry count is kept.
- LOCKED: enables 1, `clk_sel`=1, `locked`=1.
- FAIL: enables 0, `fail`=1. Held until `start`=0.
- `start`=0 in any state: IDLE on the next edge, all outputs 0 on that edge. This has priority over every other transition, including a window end on the same cycle.
- Counters are 16 bits wide. All cycle parameters must be ≥1 and ≤ 65535. A duration N means exactly N cycles in the state.

## Timing
- Let E0 be the first edge with `start`=1 in IDLE. CP_ON is entered at E0.
  - `ENb_CP`=1 after E0.
  - `ENb_VCO`=1 after E16.
  - MEASURE is entered at E272.
  - `locked`, `clk_sel` are 1 after E336 (defaults).
- Each retry adds 2·`CP_SETTLE`+`LOCK_WAIT`+`WINDOW` = 352 cycles.
- `clk_sel` and `locked` change on the same edge. `clk_sel` is never 1 while `ENb_VCO`=0.
- `RST_N`=0 mid-sequence: reset values on the next edge, regardless of state.

## Configuration
- `PLL_SEQ_MONITOR_EN` defined: LOCKED re-measures continuously, in back-to-back `WINDOW`-cycle windows.
  - A window outside tolerance clears `clk_sel` and `locked` on the window-end edge and enters RETRY_OFF with the retry count cleared to 0.
  - A lock that is regained restores the outputs.
- `PLL_SEQ_MONITOR_EN` undefined: LOCKED is terminal until `start`=0 or reset. `pll_tick` is ignored in LOCKED.

## Structure
- Package `pll_seq_pkg`:
  - state enum `pll_seq_state_t` (IDLE, CP_ON, VCO_ON, MEASURE, RETRY_OFF, LOCKED, FAIL);
  - `PLL_SEQ_CNT_W`=16, `PLL_SEQ_TICK_W`=8.
- Sub-module `pll_tick_counter`: window counter plus saturating tick counter and tolerance compare. It emits a one-cycle `done` pulse and a `pass` flag, and is restarted by the FSM.
- The FSM and duration counter live in `pll_lock_seq`.

## Test plan
- Nominal: `start`=1 at E0, `pll_tick` every 8 cycles → `ENb_CP` rises after E0, `ENb_VCO` after E16, `locked`=`clk_sel`=1 after E336, `fail`=0.
- Tolerance edges: 7 ticks and 9 ticks in the window each → locked. 6 ticks → RETRY_OFF, with `ENb_VCO`=0 after E336.
- No ticks at all → three retries, then `fail`=1 after E336+3·352 = E1392, with both enables 0.
- Drop `start` at E100 (VCO_ON) → all outputs 0 after E100. Re-raise `start` → full sequence restarts, with `ENb_VCO` rising 16 cycles after re-entry.
- `RST_N`=0 for one cycle while LOCKED → all outputs 0 next edge. With `start` held at 1, relock occurs 337 edges after reset release.
- With `PLL_SEQ_MONITOR_EN`: in LOCKED, tick rate drops to every 16 cycles (4 per window) → `locked`=`clk_sel`=0 at the window end, then relock once the rate is restored.
